// File: rtl/clkx_pkg.sv
// rtl/clkx_pkg.sv - shared types and helpers for the multi-channel req/ack bus crossing
package clkx_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    // Number of bits needed to index `value` items (0 for a single item).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clkx_sync_n.sv
// rtl/clkx_sync_n.sv - SYNC_STAGES-deep single-bit synchroniser, async active-low reset to 0
module clkx_sync_n #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/clkx_bus_hs_tx.sv
// rtl/clkx_bus_hs_tx.sv - source side of a multi-channel four-phase bus crossing; optional CLKX_TIMEOUT_EN
module clkx_bus_hs_tx
    import clkx_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int CHANNELS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW            = (clogb2(CHANNELS) < 1) ? 1 : clogb2(CHANNELS)
) (
    input  logic                      clk_src,
    input  logic                      rst_clk_src_n,
    input  logic [CHANNELS*WIDTH-1:0] bus_src,
    input  logic [CHANNELS-1:0]       bus_new_src,
    output logic                      xfer_req_src,
    output logic [WIDTH-1:0]          xfer_bus_src,
    output logic [CW-1:0]             xfer_chan_src,
    input  logic                      xfer_ack_async,
    output logic                      busy_src,
    output logic [DROP_CNT_W-1:0]     drop_cnt_src,
    output logic                      err_timeout_src
);

    if (CHANNELS < 1 || CHANNELS > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("clkx_bus_hs_tx: parameter out of range");
    end

    state_t               state, state_nxt;
    logic                 ack_s;
    logic                 launch, req_nxt, timeout_hit;
    logic                 grant_vld;
    logic [CW-1:0]        grant, rr_ptr, idx;
    logic [CHANNELS-1:0]  pend, pend_nxt, launch_mask, overwrite;
    logic [WIDTH-1:0]     pend_data [CHANNELS];

    clkx_sync_n #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_src),
        .rst_n (rst_clk_src_n),
        .d     (xfer_ack_async),
        .q     (ack_s)
    );

    // Walk downward so the pending channel closest to rr_ptr wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = CW'((int'(rr_ptr) + k) % CHANNELS);
            if (pend[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_src or negedge rst_clk_src_n) begin
        if (!rst_clk_src_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld && !ack_s) state_nxt = REQ;
            REQ:     if (ack_s || timeout_hit) state_nxt = REL;
            REL:     if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch  = (state == IDLE) && (state_nxt == REQ);
        req_nxt = (state_nxt == REQ);
    end

    // A launch consumes the old data; a same-cycle update re-arms the channel without a drop.
    always_comb begin
        launch_mask = '0;
        if (launch) begin
            launch_mask[grant] = 1'b1;
        end
        overwrite = bus_new_src & pend & ~launch_mask;
        pend_nxt  = (pend & ~launch_mask) | bus_new_src;
    end

    always_ff @(posedge clk_src or negedge rst_clk_src_n) begin
        if (!rst_clk_src_n) begin
            pend          <= '0;
            rr_ptr        <= '0;
            xfer_req_src  <= 1'b0;
            xfer_bus_src  <= '0;
            xfer_chan_src <= '0;
            busy_src      <= 1'b0;
            drop_cnt_src  <= '0;
        end else begin
            pend         <= pend_nxt;
            xfer_req_src <= req_nxt;
            busy_src     <= (|pend_nxt) | (state_nxt != IDLE);
            if ((|overwrite) && (drop_cnt_src != '1)) begin
                drop_cnt_src <= drop_cnt_src + 1'b1;
            end
            if (launch) begin
                xfer_bus_src  <= pend_data[grant];
                xfer_chan_src <= grant;
                rr_ptr        <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_src or negedge rst_clk_src_n) begin
        if (!rst_clk_src_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus_new_src[i]) begin
                    pend_data[i] <= bus_src[i*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef CLKX_TIMEOUT_EN
    localparam int TW = clogb2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Counter holds at the limit while REL waits for ack to fall.
    assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_src or negedge rst_clk_src_n) begin
        if (!rst_clk_src_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                to_cnt <= '0;
            end else if ((state != IDLE) && !timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout_src = err_q;
`else
    assign timeout_hit     = 1'b0;
    assign err_timeout_src = 1'b0;
`endif

endmodule

// File: tb/tb_clkx_bus_hs_tx.sv
// tb/tb_clkx_bus_hs_tx.sv - directed self-checking bench for clkx_bus_hs_tx
module tb_clkx_bus_hs_tx;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [CHANNELS*WIDTH-1:0] bus_src = '0;
    logic [CHANNELS-1:0]       bus_new_src = '0;
    logic                      xfer_req_src;
    logic [WIDTH-1:0]          xfer_bus_src;
    logic [1:0]                xfer_chan_src;
    logic                      xfer_ack_async = 1'b0;
    logic                      busy_src;
    logic [7:0]                drop_cnt_src;
    logic                      err_timeout_src;

    int checks = 0;
    int failures = 0;
    int stable_err = 0;

    logic [2:0]  ack_hist = '0;
    logic        ack_en = 1'b1;
    logic        req_prev = 1'b0;
    logic [15:0] last_bus = '0;
    logic [1:0]  got_chan [$];
    logic [15:0] got_bus [$];

    clkx_bus_hs_tx #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_src        (clk),
        .rst_clk_src_n  (rst_n),
        .bus_src        (bus_src),
        .bus_new_src    (bus_new_src),
        .xfer_req_src   (xfer_req_src),
        .xfer_bus_src   (xfer_bus_src),
        .xfer_chan_src  (xfer_chan_src),
        .xfer_ack_async (xfer_ack_async),
        .busy_src       (busy_src),
        .drop_cnt_src   (drop_cnt_src),
        .err_timeout_src(err_timeout_src)
    );

    always #5 clk = ~clk;

    // Destination model: ack echoes req three cycles later unless stalled.
    always @(posedge clk) begin
        #1;
        ack_hist = {ack_hist[1:0], xfer_req_src};
        xfer_ack_async = ack_en & ack_hist[2];
    end

    always @(negedge clk) begin
        if (xfer_req_src && !req_prev) begin
            got_chan.push_back(xfer_chan_src);
            got_bus.push_back(xfer_bus_src);
            last_bus = xfer_bus_src;
        end else if (xfer_req_src && (xfer_bus_src !== last_bus)) begin
            stable_err++;
        end
        req_prev = xfer_req_src;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input int ch, input logic [15:0] v);
        bus_src[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic fire(input logic [3:0] mask);
        @(negedge clk);
        bus_new_src = mask;
        @(negedge clk);
        bus_new_src = '0;
    endtask

    task automatic wait_req(input logic lvl, input int budget, input string tag);
        int n = 0;
        while ((xfer_req_src !== lvl) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(xfer_req_src === lvl), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy_src !== 1'b0) && (n < 300)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy_src), 32'd0);
    endtask

    task automatic clear_q();
        got_chan.delete();
        got_bus.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", 32'(xfer_req_src), 32'd0);
        check("rst_busy", 32'(busy_src), 32'd0);
        check("rst_drop", 32'(drop_cnt_src), 32'd0);
        check("rst_err", 32'(err_timeout_src), 32'd0);
        check("rst_bus", 32'(xfer_bus_src), 32'd0);
        check("rst_chan", 32'(xfer_chan_src), 32'd0);
        rst_n = 1'b1;

        // single update on channel 2
        clear_q();
        set_bus(2, 16'hA5A5);
        fire(4'b0100);
        check("single_req_early", 32'(xfer_req_src), 32'd0);
        check("single_busy", 32'(busy_src), 32'd1);
        @(negedge clk);
        check("single_req", 32'(xfer_req_src), 32'd1);
        check("single_chan", 32'(xfer_chan_src), 32'd2);
        check("single_bus", 32'(xfer_bus_src), 32'hA5A5);
        wait_req(1'b0, 50, "single_req_drop");
        drain("single_idle");

        // reset to put rr_ptr back at 0
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // round robin 0,1,3 then 0,3
        clear_q();
        set_bus(0, 16'h1000);
        set_bus(1, 16'h1001);
        set_bus(3, 16'h1003);
        fire(4'b1011);
        drain("rr1_drain");
        check("rr1_count", 32'(got_chan.size()), 32'd3);
        check("rr1_c0", 32'(got_chan[0]), 32'd0);
        check("rr1_c1", 32'(got_chan[1]), 32'd1);
        check("rr1_c2", 32'(got_chan[2]), 32'd3);
        check("rr1_b2", 32'(got_bus[2]), 32'h1003);
        clear_q();
        set_bus(0, 16'h2000);
        set_bus(3, 16'h2003);
        fire(4'b1001);
        drain("rr2_drain");
        check("rr2_count", 32'(got_chan.size()), 32'd2);
        check("rr2_c0", 32'(got_chan[0]), 32'd0);
        check("rr2_c1", 32'(got_chan[1]), 32'd3);
        check("rr2_b0", 32'(got_bus[0]), 32'h2000);

        // collision: new data arrives on the launch edge
        clear_q();
        set_bus(0, 16'h1111);
        fire(4'b0001);
        set_bus(0, 16'h3333);
        bus_new_src = 4'b0001;
        @(negedge clk);
        bus_new_src = '0;
        drain("coll_drain");
        check("coll_count", 32'(got_chan.size()), 32'd2);
        check("coll_b0", 32'(got_bus[0]), 32'h1111);
        check("coll_b1", 32'(got_bus[1]), 32'h3333);
        check("coll_drop", 32'(drop_cnt_src), 32'd0);

        // overwrite while channel 1 is stalled
        clear_q();
        ack_en = 1'b0;
        set_bus(1, 16'h0111);
        fire(4'b0010);
        wait_req(1'b1, 10, "ovw_launch");
        set_bus(0, 16'h1111);
        fire(4'b0001);
        set_bus(0, 16'h2222);
        fire(4'b0001);
        check("ovw_drop", 32'(drop_cnt_src), 32'd1);
        ack_en = 1'b1;
        drain("ovw_drain");
        check("ovw_count", 32'(got_chan.size()), 32'd2);
        check("ovw_c0", 32'(got_chan[0]), 32'd1);
        check("ovw_c1", 32'(got_chan[1]), 32'd0);
        check("ovw_b1", 32'(got_bus[1]), 32'h2222);

        // saturation: 300 back-to-back updates on a stalled crossing
        ack_en = 1'b0;
        fire(4'b0010);
        wait_req(1'b1, 10, "sat_launch");
        @(negedge clk);
        bus_new_src = 4'b0001;
        repeat (300) @(negedge clk);
        bus_new_src = '0;
        check("sat_drop", 32'(drop_cnt_src), 32'd255);
        ack_en = 1'b1;
        drain("sat_drain");

        // asynchronous reset in the middle of a handshake
        ack_en = 1'b0;
        fire(4'b0011);
        wait_req(1'b1, 10, "mid_launch");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_req", 32'(xfer_req_src), 32'd0);
        check("mid_busy", 32'(busy_src), 32'd0);
        check("mid_drop", 32'(drop_cnt_src), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_no_req", 32'(xfer_req_src), 32'd0);
        check("mid_no_pend", 32'(busy_src), 32'd0);
        clear_q();
        set_bus(3, 16'hBEEF);
        fire(4'b1000);
        wait_req(1'b1, 10, "restart_launch");
        check("restart_chan", 32'(xfer_chan_src), 32'd3);
        check("restart_bus", 32'(xfer_bus_src), 32'hBEEF);
        drain("restart_drain");

`ifdef CLKX_TIMEOUT_EN
        ack_en = 1'b0;
        set_bus(1, 16'h0A01);
        set_bus(2, 16'h0A02);
        fire(4'b0110);
        wait_req(1'b1, 10, "to_launch");
        repeat (15) @(negedge clk);
        check("to_err_early", 32'(err_timeout_src), 32'd0);
        check("to_req_held", 32'(xfer_req_src), 32'd1);
        @(negedge clk);
        check("to_err", 32'(err_timeout_src), 32'd1);
        check("to_req_drop", 32'(xfer_req_src), 32'd0);
        wait_req(1'b1, 10, "to_next");
        check("to_next_chan", 32'(xfer_chan_src), 32'd2);
        ack_en = 1'b1;
        drain("to_drain");
        check("to_err_sticky", 32'(err_timeout_src), 32'd1);
`else
        check("err_tied", 32'(err_timeout_src), 32'd0);
`endif

        check("bus_stable", 32'(stable_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkx_bus_hs_tx.md
Name: clkx_bus_hs_tx

Overview:
- Source-side half of a multi-channel, four-phase req/ack bus crossing. Successor to the single-bus pulse-stretch crossing.
- Accepts infrequent bus updates on CHANNELS independent channels.
- Holds the latest value per channel and arbitrates round-robin among pending channels.
- Presents one word at a time to the destination domain with a full req/ack handshake. No minimum pulse width and no assumptions on clock ratio.
- Sits in the source clock domain. The matching receiver lives in the destination domain.

Parameters:
- WIDTH, 16: bus width per channel.
- CHANNELS, 4: number of independent input channels, 1..16.
- SYNC_STAGES, 2: flops in the ack synchroniser, 2..4.
- TIMEOUT_CYCLES, 1024: handshake timeout in clk_src cycles. Used only with CLKX_TIMEOUT_EN.

Ports:
- clk_src  in  1  source clock; the only clock.
- rst_clk_src_n  in  1  asynchronous, active-low reset.
- bus_src  in  CHANNELS*WIDTH  channel buses, channel i at bits [i*WIDTH +: WIDTH].
- bus_new_src  in  CHANNELS  one-cycle pulse per channel; that channel's bus has a new value this cycle.
- xfer_req_src  out  1  four-phase request to destination domain.
- xfer_bus_src  out  WIDTH  word being transferred; stable while xfer_req_src=1.
- xfer_chan_src  out  CW  channel id of xfer_bus_src, where CW = max(1, clogb2(CHANNELS)).
- xfer_ack_async  in  1  acknowledge from destination domain; asynchronous to clk_src.
- busy_src  out  1  high when any channel is pending or a handshake is in progress.
- drop_cnt_src  out  8  saturating count of overwritten (lost) pending updates.
- err_timeout_src  out  1  sticky timeout flag. Tied 0 without CLKX_TIMEOUT_EN.

Behaviour:
- Reset: all outputs 0, all pending bits 0, synchroniser flops 0, RR pointer 0, FSM in IDLE. Reset is asynchronous, so xfer_req_src drops immediately, including mid-handshake.
- Capture: on bus_new_src[i], pend_data[i] <= bus_src slice i and pend[i] <= 1 on the next edge.
  - If pend[i] was already 1 and not being launched this cycle, the new data overwrites the old and drop_cnt increments, saturating at 255.
  - drop_cnt increments by at most 1 per cycle, even if several channels overwrite in the same cycle.
- ack_s: xfer_ack_async passed through SYNC_STAGES flops.
- FSM states: IDLE, REQ, REL.
  - IDLE: if any pend bit is set, grant the first pending channel searching from rr_ptr upward with wrap. Load xfer_bus_src / xfer_chan_src, clear that pend bit, set xfer_req_src=1, set rr_ptr = grant+1 mod CHANNELS, go to REQ.
  - IDLE requires ack_s=0 to launch. If ack_s=1, stay in IDLE.
  - REQ: hold req and data. When ack_s=1, drop req, go to REL.
  - REL: when ack_s=0, go to IDLE.
- Latency: bus_new_src at edge N, pend set at N+1, req high after edge N+2 when idle. Minimum cycle-to-cycle turnaround is 2*SYNC_STAGES plus destination latency.
- Simultaneous launch and new on the same channel: launch takes the old pend_data. pend[i] re-sets with the new data and no drop is counted.
- Simultaneous new on several channels: all are captured, then served in RR order.
- CHANNELS=1: arbitration degenerates and xfer_chan_src is constant 0.
- busy_src = |pend | (state != IDLE), registered.

Optional Feature:
- Macro CLKX_TIMEOUT_EN.
- Defined: a counter runs in REQ and REL. When it reaches TIMEOUT_CYCLES, set err_timeout_src (sticky until reset), drop req, and go to REL. The transfer is lost and not retried. The counter clears on every state change.
- Undefined: no counter is built, err_timeout_src is tied 0, and the FSM waits forever.

Decomposition:
- Shared package clkx_pkg holds:
  - FSM state typedef: IDLE=2'd0, REQ=2'd1, REL=2'd2.
  - clogb2 function.
  - DROP_CNT_W=8 constant.
- One sub-module, clkx_sync_n: parametrised SYNC_STAGES single-bit synchroniser with async active-low reset to 0. The receiver reuses it for req.

Test Plan:
- Single update: WIDTH=16, bus_new_src[2] with 16'hA5A5 and the ack model echoes req after 3 cycles. Expect req within 2 cycles, xfer_chan=2, bus=A5A5 stable until ack_s, req low, then busy_src=0.
- Round-robin: pulse channels 0,1,3 in the same cycle. Expect transfers in order 0,1,3. Then pulse 0 and 3 with rr_ptr=0 (after 3), expect 0 then 3.
- Overwrite: while a channel 1 handshake is stalled, pulse ch0 with 1111 then 2222. Expect only 2222 sent and drop_cnt=1. Do this 300 times and expect drop_cnt saturates at 255.
- Collision: bus_new_src[0]=3333 in the same cycle ch0 is launched with 1111. Expect 1111 sent, then 3333, and drop_cnt unchanged.
- Reset mid-REQ: assert rst_clk_src_n=0 asynchronously while req=1. Expect req=0 with no clock edge, all pend cleared, and a clean restart after release.
- CLKX_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack held 0: expect err_timeout_src=1 exactly 16 cycles after req rises, req low, FSM back in IDLE, and the next pending channel served.
